// File: rtl/fb_port_responder_if.sv
// rtl/fb_port_responder_if.sv - VGA fetch, CPU data-bus and framebuffer RAM signals of the port responder
interface fb_port_responder_if #(
  parameter int ADDR_WIDTH = 16
);
  logic                  fb_access;
  logic [ADDR_WIDTH-1:0] fb_address;
  logic                  fb_ack;
  logic [15:0]           fb_data;

  logic                  cs;
  logic                  data_m_access;
  logic                  data_m_wr_en;
  logic [ADDR_WIDTH-1:0] data_m_addr;
  logic [15:0]           data_m_data_in;
  logic [1:0]            data_m_bytesel;
  logic [15:0]           data_m_data_out;
  logic                  data_m_ack;

  logic [ADDR_WIDTH-1:0] ram_address;
  logic                  ram_wr_en;
  logic [1:0]            ram_bytesel;
  logic [15:0]           ram_wdata;
  logic [15:0]           ram_rdata;

  modport slave (
    input  fb_access, fb_address,
    output fb_ack, fb_data,
    input  cs, data_m_access, data_m_wr_en, data_m_addr, data_m_data_in, data_m_bytesel,
    output data_m_data_out, data_m_ack,
    output ram_address, ram_wr_en, ram_bytesel, ram_wdata,
    input  ram_rdata
  );

  modport master (
    output fb_access, fb_address,
    input  fb_ack, fb_data,
    output cs, data_m_access, data_m_wr_en, data_m_addr, data_m_data_in, data_m_bytesel,
    input  data_m_data_out, data_m_ack,
    input  ram_address, ram_wr_en, ram_bytesel, ram_wdata,
    output ram_rdata
  );
endinterface

// File: rtl/fb_port_responder.sv
// rtl/fb_port_responder.sv - framebuffer RAM arbiter for VGA prefetch reads and CPU accesses
// Optional FB_CPU_FAIRNESS_EN forces a waiting CPU access through after VGA_BURST_MAX VGA grants.
module fb_port_responder #(
  parameter int ADDR_WIDTH    = 16,
  parameter int VGA_BURST_MAX = 8
) (
  input logic                 sys_clk,
  input logic                 reset_n,
  fb_port_responder_if.slave  bus
);
  typedef enum logic [2:0] {
    IDLE,
    VGA_RD,
    VGA_ACK,
    CPU_RD,
    CPU_ACK,
    CPU_WR
  } state_t;

  localparam logic [3:0] BURST_LIMIT = 4'(VGA_BURST_MAX);

  state_t                state;
  logic                  fb_ack_q;
  logic                  cpu_ack_q;
  logic                  cpu_ack_rd_q;
  logic                  cpu_hold;
  logic [ADDR_WIDTH-1:0] ram_address_q;
  logic                  ram_wr_en_q;
  logic [1:0]            ram_bytesel_q;
  logic [15:0]           ram_wdata_q;

  logic vga_req;
  logic cpu_req;
  logic cpu_first;
  logic grant_cpu;
  logic grant_vga;

  // A CPU master may take one cycle to drop its request after the ack
  assign vga_req   = bus.fb_access;
  assign cpu_req   = bus.cs & bus.data_m_access & ~cpu_hold;
  assign grant_cpu = (state == IDLE) & cpu_req & (cpu_first | ~vga_req);
  assign grant_vga = (state == IDLE) & vga_req & ~grant_cpu;

`ifdef FB_CPU_FAIRNESS_EN
  logic [3:0] burst_cnt;

  assign cpu_first = cpu_req & (burst_cnt >= BURST_LIMIT);

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      burst_cnt <= '0;
    end else if (state == IDLE) begin
      if (grant_cpu || !cpu_req) begin
        burst_cnt <= '0;
      end else if (grant_vga) begin
        burst_cnt <= burst_cnt + 4'd1;
      end
    end
  end
`else
  logic unused_burst_limit;

  assign cpu_first          = 1'b0;
  assign unused_burst_limit = ^BURST_LIMIT;
`endif

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      fb_ack_q      <= 1'b0;
      cpu_ack_q     <= 1'b0;
      cpu_ack_rd_q  <= 1'b0;
      cpu_hold      <= 1'b0;
      ram_address_q <= '0;
      ram_wr_en_q   <= 1'b0;
      ram_bytesel_q <= '0;
      ram_wdata_q   <= '0;
    end else begin
      fb_ack_q    <= 1'b0;
      cpu_ack_q   <= 1'b0;
      ram_wr_en_q <= 1'b0;
      cpu_hold    <= (state == CPU_ACK);
      unique case (state)
        IDLE: begin
          if (grant_cpu) begin
            ram_address_q <= bus.data_m_addr;
            if (bus.data_m_wr_en) begin
              ram_wdata_q   <= bus.data_m_data_in;
              ram_bytesel_q <= bus.data_m_bytesel;
              ram_wr_en_q   <= 1'b1;
              state         <= CPU_WR;
            end else begin
              state <= CPU_RD;
            end
          end else if (grant_vga) begin
            ram_address_q <= bus.fb_address;
            state         <= VGA_RD;
          end
        end
        VGA_RD: begin
          fb_ack_q <= 1'b1;
          state    <= VGA_ACK;
        end
        VGA_ACK: state <= IDLE;
        CPU_RD: begin
          cpu_ack_q    <= 1'b1;
          cpu_ack_rd_q <= 1'b1;
          state        <= CPU_ACK;
        end
        CPU_WR: begin
          cpu_ack_q    <= 1'b1;
          cpu_ack_rd_q <= 1'b0;
          state        <= CPU_ACK;
        end
        CPU_ACK: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // RAM read data arrives in the ack cycle itself, so the data outputs are gated rather than registered
  assign bus.fb_ack          = fb_ack_q;
  assign bus.fb_data         = fb_ack_q ? bus.ram_rdata : 16'h0000;
  assign bus.data_m_ack      = cpu_ack_q;
  assign bus.data_m_data_out = (cpu_ack_q & cpu_ack_rd_q) ? bus.ram_rdata : 16'h0000;
  assign bus.ram_address     = ram_address_q;
  assign bus.ram_wr_en       = ram_wr_en_q;
  assign bus.ram_bytesel     = ram_bytesel_q;
  assign bus.ram_wdata       = ram_wdata_q;
endmodule

// File: tb/tb_fb_port_responder.sv
// tb/tb_fb_port_responder.sv - scoreboard bench for fb_port_responder with a framebuffer RAM model
module tb_fb_port_responder;
  localparam int AW    = 16;
  localparam int BURST = 8;
`ifdef FB_CPU_FAIRNESS_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic sys_clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 sys_clk = ~sys_clk;

  fb_port_responder_if #(.ADDR_WIDTH(AW)) bus ();

  fb_port_responder #(.ADDR_WIDTH(AW), .VGA_BURST_MAX(BURST)) dut (
    .sys_clk (sys_clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Synchronous single-port framebuffer RAM
  logic [15:0] mem [0:65535];
  always @(posedge sys_clk) begin
    bus.ram_rdata <= mem[bus.ram_address];
    if (bus.ram_wr_en === 1'b1) begin
      if (bus.ram_bytesel[0]) mem[bus.ram_address][7:0]  = bus.ram_wdata[7:0];
      if (bus.ram_bytesel[1]) mem[bus.ram_address][15:8] = bus.ram_wdata[15:8];
    end
  end

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  // Reference contents: preload rule plus every CPU write applied byte-wise
  logic [15:0] shadow [logic [15:0]];

  function automatic logic [15:0] ref_rd(input logic [15:0] a);
    if (shadow.exists(a)) return shadow[a];
    return a ^ 16'h5a5a;
  endfunction

  function automatic void ref_wr(input logic [15:0] a, input logic [15:0] d, input logic [1:0] be);
    logic [15:0] w;
    w = ref_rd(a);
    if (be[0]) w[7:0]  = d[7:0];
    if (be[1]) w[15:8] = d[15:8];
    shadow[a] = w;
  endfunction

  typedef struct {
    logic [15:0] data;
    int          lo;
    int          hi;
    string       name;
  } exp_t;

  exp_t vga_q[$];
  exp_t cpu_q[$];
  exp_t mon_e;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endfunction

  function automatic void chk_win(input string name, input int act, input int lo, input int hi);
    total++;
    if (act < lo || act > hi) begin
      bad++;
      $display("FAIL %s: got cycle %0d want %0d..%0d", name, act, lo, hi);
    end
  endfunction

  function automatic void fail_now(input string name, input string what);
    total++;
    bad++;
    $display("FAIL %s: got %s want ack", name, what);
  endfunction

  function automatic void push_vga(input logic [15:0] d, input int lo, input int hi, input string n);
    exp_t e;
    e.data = d; e.lo = lo; e.hi = hi; e.name = n;
    vga_q.push_back(e);
  endfunction

  function automatic void push_cpu(input logic [15:0] d, input int lo, input int hi, input string n);
    exp_t e;
    e.data = d; e.lo = lo; e.hi = hi; e.name = n;
    cpu_q.push_back(e);
  endfunction

  // Monitor: every ack pops the oldest expectation; outputs must read 0 otherwise
  always @(negedge sys_clk) begin
    if (reset_n) begin
      if (bus.fb_ack === 1'b1) begin
        if (vga_q.size() == 0) begin
          total++; bad++;
          $display("FAIL vga_spurious_ack: got ack at cycle %0d want none", cyc);
        end else begin
          mon_e = vga_q.pop_front();
          chk({mon_e.name, "_data"}, 32'(bus.fb_data), 32'(mon_e.data));
          chk_win({mon_e.name, "_cycle"}, cyc, mon_e.lo, mon_e.hi);
        end
      end else begin
        chk("fb_data_idle", 32'(bus.fb_data), 32'h0);
      end
      if (bus.data_m_ack === 1'b1) begin
        if (cpu_q.size() == 0) begin
          total++; bad++;
          $display("FAIL cpu_spurious_ack: got ack at cycle %0d want none", cyc);
        end else begin
          mon_e = cpu_q.pop_front();
          chk({mon_e.name, "_data"}, 32'(bus.data_m_data_out), 32'(mon_e.data));
          chk_win({mon_e.name, "_cycle"}, cyc, mon_e.lo, mon_e.hi);
        end
      end else begin
        chk("cpu_data_idle", 32'(bus.data_m_data_out), 32'h0);
      end
    end
  end

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic wait_fb_ack(input int limit);
    int t;
    t = 0;
    do begin
      @(negedge sys_clk);
      t++;
    end while (bus.fb_ack !== 1'b1 && t < limit);
    if (bus.fb_ack !== 1'b1) fail_now("fb_ack_wait", "timeout");
  endtask

  task automatic wait_cpu_ack(input int limit);
    int t;
    t = 0;
    do begin
      @(negedge sys_clk);
      t++;
    end while (bus.data_m_ack !== 1'b1 && t < limit);
    if (bus.data_m_ack !== 1'b1) fail_now("cpu_ack_wait", "timeout");
  endtask

  // Prefetcher: presents the next address in the cycle after each ack
  task automatic vga_stream(input logic [15:0] start, input int n, input int slack);
    logic [15:0] a;
    for (int i = 0; i < n; i++) begin
      a = start + 16'(i);
      bus.fb_address = a;
      bus.fb_access  = 1'b1;
      push_vga(ref_rd(a), cyc + 2, cyc + 2 + slack, "vga_rd");
      wait_fb_ack(40);
      step();
    end
    bus.fb_access = 1'b0;
  endtask

  task automatic cpu_op(input logic wr, input logic [15:0] a, input logic [15:0] d,
                        input logic [1:0] be, input int lo, input int hi,
                        input bit slow, input int limit);
    bus.cs             = 1'b1;
    bus.data_m_access  = 1'b1;
    bus.data_m_wr_en   = wr;
    bus.data_m_addr    = a;
    bus.data_m_data_in = d;
    bus.data_m_bytesel = be;
    if (wr) begin
      ref_wr(a, d, be);
      push_cpu(16'h0000, cyc + lo, cyc + hi, "cpu_wr");
    end else begin
      push_cpu(ref_rd(a), cyc + lo, cyc + hi, "cpu_rd");
    end
    wait_cpu_ack(limit);
    step();
    if (slow) step();
    bus.data_m_access = 1'b0;
    bus.cs            = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int          kind;
    int          r;
    logic [15:0] ra;
    logic [15:0] rd;

    for (int a = 0; a < 65536; a++) mem[16'(a)] = 16'(a) ^ 16'h5a5a;
    mem[16'h1000]    = 16'h0000;
    shadow[16'h1000] = 16'h0000;

    // Reset held with every request asserted
    bus.fb_access      = 1'b1;
    bus.fb_address     = 16'h0010;
    bus.cs             = 1'b1;
    bus.data_m_access  = 1'b1;
    bus.data_m_wr_en   = 1'b1;
    bus.data_m_addr    = 16'h3000;
    bus.data_m_data_in = 16'hffff;
    bus.data_m_bytesel = 2'b11;
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    chk("rst_fb_ack",      32'(bus.fb_ack),          32'h0);
    chk("rst_fb_data",     32'(bus.fb_data),         32'h0);
    chk("rst_cpu_ack",     32'(bus.data_m_ack),      32'h0);
    chk("rst_cpu_data",    32'(bus.data_m_data_out), 32'h0);
    chk("rst_ram_address", 32'(bus.ram_address),     32'h0);
    chk("rst_ram_wr_en",   32'(bus.ram_wr_en),       32'h0);
    chk("rst_ram_wdata",   32'(bus.ram_wdata),       32'h0);
    chk("rst_ram_bytesel", 32'(bus.ram_bytesel),     32'h0);
    step();
    bus.cs            = 1'b0;
    bus.data_m_access = 1'b0;
    reset_n           = 1'b1;
    vga_stream(16'h0010, 1, 0);

    step();
    vga_stream(16'h0140, 80, 0);
    step();
    vga_stream(16'hfffe, 4, 0);

    step();
    cpu_op(1'b1, 16'h1000, 16'hbeef, 2'b01, 2, 2, 1'b0, 20);
    step();
    cpu_op(1'b0, 16'h1000, 16'h0000, 2'b00, 2, 2, 1'b0, 20);

    // Simultaneous VGA and CPU read; CPU master drops its request one cycle late
    step();
    fork
      vga_stream(16'h0200, 1, 0);
      cpu_op(1'b0, 16'h0300, 16'h0000, 2'b00, 5, 5, 1'b1, 20);
    join
    repeat (3) step();

    // CPU write against a continuous 40-word VGA stream, raised alongside the fourth fetch
    fork
      vga_stream(16'h0400, 40, FAIR ? 3 : 0);
      begin
        repeat (9) step();
        cpu_op(1'b1, 16'h2000, 16'h1234, 2'b11,
               FAIR ? 2 : (3 * 40 + 2 - 9), FAIR ? 27 : (3 * 40 + 2 - 9), 1'b0, 300);
      end
    join

    // Reset pulse while in VGA_RD aborts the fetch; the held request is served afresh
    step();
    step();
    bus.fb_address = 16'h0777;
    bus.fb_access  = 1'b1;
    push_vga(ref_rd(16'h0777), cyc + 3, cyc + 3, "vga_after_reset");
    step();
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
    wait_fb_ack(20);
    step();
    bus.fb_access = 1'b0;

    for (int i = 0; i < 30; i++) begin
      repeat ($urandom_range(1, 3)) step();
      kind = $urandom_range(0, 3);
      r    = $urandom_range(0, 7);
      ra   = (r == 0) ? 16'hffff : ((r == 1) ? 16'h0000 : 16'($urandom));
      rd   = 16'($urandom);
      case (kind)
        0: vga_stream(ra, 1, 0);
        1: cpu_op(1'b0, ra, 16'h0000, 2'b00, 2, 2, 1'($urandom_range(0, 1)), 20);
        2: cpu_op(1'b1, ra, rd, 2'($urandom_range(0, 3)), 2, 2, 1'($urandom_range(0, 1)), 20);
        default: begin
          bus.cs             = 1'b0;
          bus.data_m_access  = 1'b1;
          bus.data_m_wr_en   = 1'($urandom_range(0, 1));
          bus.data_m_addr    = ra;
          bus.data_m_data_in = rd;
          repeat (4) step();
          bus.data_m_access  = 1'b0;
        end
      endcase
    end

    repeat (6) step();
    chk("vga_q_drained", 32'(vga_q.size()), 32'h0);
    chk("cpu_q_drained", 32'(cpu_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
